// File: rtl/mul_checker.sv
// mul_checker: scoreboard-style checker for a multi-cycle multiplier DUT.
// Latches the operands on start, computes the full 2*WIDTH reference
// product, and compares it with the DUT product on finish. It also flags
// timeouts and start/finish protocol violations and keeps pass/fail counts.
//
// Optional latency statistics (lat_last / lat_max) are enabled by defining
// MUL_CHECKER_STATS_EN. Without it both outputs are tied to 0 and their
// registers are not built.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transaction outstanding; finish here is a protocol error
// S_WAIT | operands latched, waiting for finish or the timeout limit
module mul_checker #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 finish,
    output logic                 error,
    output logic                 check_valid,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 proto_err,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     lat_last,
    output logic [CNT_W-1:0]     lat_max
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    state_t               state;
    state_t               next_state;

    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 sm_q;
    logic [CNT_W-1:0]     cnt;

    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic [2*WIDTH-1:0]   expected;

    logic                 do_check;
    logic                 do_timeout;
    logic                 do_proto;
    logic                 mismatch;

    // Reference product from the latched operands only. Multiplying the
    // 2*WIDTH extended operands and keeping the low 2*WIDTH bits gives the
    // exact signed or unsigned product depending on the extension.
    always_comb begin
        ext_a    = sm_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b    = sm_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        expected = ext_a * ext_b;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a start is always accepted (new, back-to-back or restart);
    // otherwise a check or timeout returns the FSM to idle.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = S_WAIT;
        end else if (state == S_WAIT && (finish || cnt == CNT_TIMEOUT)) begin
            next_state = S_IDLE;
        end
    end

    // Event decode. A start without finish in WAIT restarts the transaction,
    // so it takes precedence over a timeout landing on the same edge.
    always_comb begin
        do_check   = (state == S_WAIT) && finish;
        do_timeout = (state == S_WAIT) && !finish && !start && (cnt == CNT_TIMEOUT);
        do_proto   = ((state == S_WAIT) && start && !finish) ||
                     ((state == S_IDLE) && finish);
        mismatch   = (product != expected);
    end

    // Operand capture and cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q  <= '0;
            b_q  <= '0;
            sm_q <= 1'b0;
            cnt  <= '0;
        end else begin
            if (start) begin
                a_q  <= multiplicand;
                b_q  <= multiplier;
                sm_q <= signed_mode;
                cnt  <= CNT_W'(1);
            end else if (do_check || do_timeout) begin
                cnt  <= '0;
            end else if (state == S_WAIT) begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

    // Check results, sticky flags and saturating pass/fail counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            error       <= 1'b0;
            check_valid <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            pass_count  <= '0;
            err_count   <= '0;
        end else begin
            check_valid <= do_check || do_timeout;
            if (do_proto) begin
                proto_err <= 1'b1;
            end
            if (do_check) begin
                error <= mismatch;
                if (mismatch) begin
                    if (err_count != CNT_SAT) err_count <= err_count + 1'b1;
                end else begin
                    if (pass_count != CNT_SAT) pass_count <= pass_count + 1'b1;
                end
            end else if (do_timeout) begin
                error       <= 1'b1;
                timeout_err <= 1'b1;
                if (err_count != CNT_SAT) err_count <= err_count + 1'b1;
            end
        end
    end

`ifdef MUL_CHECKER_STATS_EN
    logic [CNT_W-1:0] lat_last_q;
    logic [CNT_W-1:0] lat_max_q;

    // Latency of completed checks; timeouts are not completions.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_last_q <= '0;
            lat_max_q  <= '0;
        end else if (do_check) begin
            lat_last_q <= cnt;
            if (cnt > lat_max_q) lat_max_q <= cnt;
        end
    end

    assign lat_last = lat_last_q;
    assign lat_max  = lat_max_q;
`else
    assign lat_last = '0;
    assign lat_max  = '0;
`endif

    assign busy = (state == S_WAIT);

endmodule

// File: tb/tb_mul_checker.sv
// Directed testbench for mul_checker (WIDTH=32, TIMEOUT=64, CNT_W=16).
module tb_mul_checker;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

`ifdef MUL_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk;
    logic                 rstn;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 signed_mode;
    logic                 start;
    logic [2*WIDTH-1:0]   product;
    logic                 finish;
    logic                 error;
    logic                 check_valid;
    logic                 busy;
    logic                 timeout_err;
    logic                 proto_err;
    logic [CNT_W-1:0]     pass_count;
    logic [CNT_W-1:0]     err_count;
    logic [CNT_W-1:0]     lat_last;
    logic [CNT_W-1:0]     lat_max;

    int compared   = 0;
    int mismatched = 0;

    mul_checker #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .start        (start),
        .product      (product),
        .finish       (finish),
        .error        (error),
        .check_valid  (check_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .proto_err    (proto_err),
        .pass_count   (pass_count),
        .err_count    (err_count),
        .lat_last     (lat_last),
        .lat_max      (lat_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lat_exp(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".error"},       64'(error),       64'd0);
        check({tag, ".check_valid"}, 64'(check_valid), 64'd0);
        check({tag, ".busy"},        64'(busy),        64'd0);
        check({tag, ".timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, ".proto_err"},   64'(proto_err),   64'd0);
        check({tag, ".pass_count"},  64'(pass_count),  64'd0);
        check({tag, ".err_count"},   64'(err_count),   64'd0);
        check({tag, ".lat_last"},    64'(lat_last),    64'd0);
        check({tag, ".lat_max"},     64'(lat_max),     64'd0);
    endtask

    initial begin
        rstn         = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        signed_mode  = 1'b0;
        start        = 1'b0;
        product      = '0;
        finish       = 1'b0;
        #3;
        check_all_zero("reset");
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Case 1: unsigned 3x5, operands disturbed after start, finish 4 cycles later.
        multiplicand = 32'd3; multiplier = 32'd5; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; multiplicand = 32'd7; multiplier = 32'd7;
        check("c1.busy", 64'(busy), 64'd1);
        tick(); tick(); tick();
        finish = 1'b1; product = 64'd15;
        tick();
        finish = 1'b0;
        check("c1.error",       64'(error),       64'd0);
        check("c1.check_valid", 64'(check_valid), 64'd1);
        check("c1.pass_count",  64'(pass_count),  64'd1);
        check("c1.busy",        64'(busy),        64'd0);
        check("c1.lat_last",    64'(lat_last),    lat_exp(4));
        tick();
        check("c1.valid_pulse", 64'(check_valid), 64'd0);

        // Case 2a: signed -2 * 3.
        multiplicand = 32'hFFFF_FFFE; multiplier = 32'd3; signed_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; finish = 1'b1; product = 64'hFFFF_FFFF_FFFF_FFFA;
        tick();
        finish = 1'b0;
        check("c2s.error",      64'(error),      64'd0);
        check("c2s.pass_count", 64'(pass_count), 64'd2);
        check("c2s.lat_last",   64'(lat_last),   lat_exp(1));
        check("c2s.lat_max",    64'(lat_max),    lat_exp(4));

        // Case 2b: same bits, unsigned.
        signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; finish = 1'b1; product = 64'h0000_0002_FFFF_FFFA;
        tick();
        finish = 1'b0;
        check("c2u.error",      64'(error),      64'd0);
        check("c2u.pass_count", 64'(pass_count), 64'd3);

        // Case 2c: signed result presented for an unsigned transaction.
        signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; finish = 1'b1; product = 64'hFFFF_FFFF_FFFF_FFFA;
        signed_mode = 1'b1;
        tick();
        finish = 1'b0;
        check("c2x.error",       64'(error),       64'd1);
        check("c2x.check_valid", 64'(check_valid), 64'd1);
        check("c2x.err_count",   64'(err_count),   64'd1);
        check("c2x.pass_count",  64'(pass_count),  64'd3);
        tick();
        check("c2x.error_hold",  64'(error),       64'd1);

        // Case 4a: finish while idle.
        finish = 1'b1; product = 64'd0;
        tick();
        finish = 1'b0;
        check("c4a.proto_err",   64'(proto_err),   64'd1);
        check("c4a.pass_count",  64'(pass_count),  64'd3);
        check("c4a.err_count",   64'(err_count),   64'd1);
        check("c4a.check_valid", 64'(check_valid), 64'd0);
        check("c4a.busy",        64'(busy),        64'd0);

        // Case 4b: restart two cycles in; the second operands are checked.
        multiplicand = 32'd2; multiplier = 32'd3; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        multiplicand = 32'd4; multiplier = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("c4b.busy",        64'(busy),        64'd1);
        check("c4b.check_valid", 64'(check_valid), 64'd0);
        check("c4b.err_count",   64'(err_count),   64'd1);
        finish = 1'b1; product = 64'd20;
        tick();
        finish = 1'b0;
        check("c4b.error",      64'(error),      64'd0);
        check("c4b.pass_count", 64'(pass_count), 64'd4);
        check("c4b.proto_err",  64'(proto_err),  64'd1);
        check("c4b.lat_last",   64'(lat_last),   lat_exp(1));

        // Case 3: timeout on counter == 64.
        multiplicand = 32'd1; multiplier = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) tick();
        check("c3.busy_before",  64'(busy),        64'd1);
        check("c3.to_before",    64'(timeout_err), 64'd0);
        check("c3.valid_before", 64'(check_valid), 64'd0);
        tick();
        check("c3.timeout_err", 64'(timeout_err), 64'd1);
        check("c3.error",       64'(error),       64'd1);
        check("c3.busy",        64'(busy),        64'd0);
        check("c3.check_valid", 64'(check_valid), 64'd1);
        check("c3.err_count",   64'(err_count),   64'd2);
        check("c3.pass_count",  64'(pass_count),  64'd4);
        check("c3.lat_last",    64'(lat_last),    lat_exp(1));
        tick();
        check("c3.valid_pulse", 64'(check_valid), 64'd0);

        // Case 5: back-to-back start+finish, then reset mid-WAIT.
        multiplicand = 32'd6; multiplier = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        multiplicand = 32'd8; multiplier = 32'd9; start = 1'b1;
        finish = 1'b1; product = 64'd42;
        tick();
        start = 1'b0; finish = 1'b0;
        check("c5.check_valid", 64'(check_valid), 64'd1);
        check("c5.error",       64'(error),       64'd0);
        check("c5.pass_count",  64'(pass_count),  64'd5);
        check("c5.busy",        64'(busy),        64'd1);
        check("c5.lat_last",    64'(lat_last),    lat_exp(2));
        check("c5.lat_max",     64'(lat_max),     lat_exp(4));
        tick();
        check("c5.busy_hold",   64'(busy),        64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("c5.rst");
        tick();
        rstn = 1'b1;
        tick(); tick();
        check_all_zero("c5.post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
